// File: rtl/gslcd_timing_gen.sv
// LCD timing generator and pixel sequencer: raster counters, sync/DEN generation and
// pixel selection from an upstream stream or a built-in pattern engine.
module gslcd_timing_gen #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 48,
  parameter int   H_BP       = 40,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 13,
  parameter int   V_SYNC     = 3,
  parameter int   V_BP       = 29,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   COMP_WIDTH = 8,
  parameter int   CNT_WIDTH  = 12,
  localparam int  DATA_WIDTH = 3 * COMP_WIDTH
) (
  input  logic                  io_pclk,
  input  logic                  reset,
  input  logic                  io_enable,
  input  logic [1:0]            io_mode,
  input  logic [DATA_WIDTH-1:0] io_color,
  input  logic                  io_pixel_valid,
  input  logic [DATA_WIDTH-1:0] io_pixel_data,
  input  logic                  io_pixel_sof,
  output logic                  io_pixel_ready,
  output logic                  io_den,
  output logic                  io_hsync,
  output logic                  io_vsync,
  output logic [DATA_WIDTH-1:0] io_data,
  output logic                  io_frame_start,
  output logic                  io_underflow,
  output logic                  io_sync_err,
  input  logic                  io_err_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_ACT_C  = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_SYNC_S = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] H_SYNC_E = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_ACT_C  = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_SYNC_S = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] V_SYNC_E = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] BAR_LAST = CNT_WIDTH'(H_ACTIVE / 8 - 1);

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_SOLID  = 2'd1;
  localparam logic [1:0] MODE_BARS   = 2'd2;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps onto index bits.
  function automatic logic [DATA_WIDTH-1:0] bar_color(input logic [2:0] idx);
    return {{COMP_WIDTH{~idx[1]}}, {COMP_WIDTH{~idx[2]}}, {COMP_WIDTH{~idx[0]}}};
  endfunction

  logic [CNT_WIDTH-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_WIDTH-1:0]  v_cnt_q, v_cnt_d;
  logic [CNT_WIDTH-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [1:0]            mode_q;
  logic [1:0]            mode_eff;
  logic                  at_origin;
  logic                  active;
  logic                  h_in_sync;
  logic                  v_in_sync;
  logic                  stream_take;
  logic                  underflow_set;
  logic                  sync_err_set;
  logic [DATA_WIDTH-1:0] pix_d;

  logic                  den_q;
  logic                  hsync_q;
  logic                  vsync_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  frame_start_q;
  logic                  underflow_q;
  logic                  sync_err_q;

  // Raster position and bar tracking (bar index follows h_cnt without a divider).
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (!io_enable) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d   = '0;
      v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_WIDTH'(1);
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else begin
      h_cnt_d = h_cnt_q + CNT_WIDTH'(1);
      if (bar_idx_q != 3'd7 && bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // The frame's first pixel already uses the mode being latched on that same cycle.
  always_comb begin
    at_origin     = (h_cnt_q == '0) && (v_cnt_q == '0);
    active        = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    h_in_sync     = (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
    v_in_sync     = (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
    mode_eff      = at_origin ? io_mode : mode_q;
    io_pixel_ready = !reset && io_enable && (mode_eff == MODE_STREAM) && active;
    stream_take   = io_pixel_ready && io_pixel_valid;
    underflow_set = io_pixel_ready && !io_pixel_valid;
    sync_err_set  = at_origin && stream_take && !io_pixel_sof;
  end

  always_comb begin
    pix_d = '0;
    if (active) begin
      case (mode_eff)
        MODE_STREAM: pix_d = stream_take ? io_pixel_data : '0;
        MODE_SOLID:  pix_d = io_color;
        MODE_BARS:   pix_d = bar_color(bar_idx_q);
        default:     pix_d = {COMP_WIDTH'(h_cnt_q), COMP_WIDTH'(v_cnt_q),
                              COMP_WIDTH'(h_cnt_q) + COMP_WIDTH'(v_cnt_q)};
      endcase
    end
  end

  // Output stage: everything registered one cycle after the counter state it decodes.
  always_ff @(posedge io_pclk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      mode_q        <= MODE_STREAM;
      den_q         <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      data_q        <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      if (io_enable && at_origin) begin
        mode_q <= io_mode;
      end
      if (!io_enable) begin
        den_q         <= 1'b0;
        hsync_q       <= ~HSYNC_POL;
        vsync_q       <= ~VSYNC_POL;
        data_q        <= '0;
        frame_start_q <= 1'b0;
      end else begin
        den_q         <= active;
        hsync_q       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        data_q        <= pix_d;
        frame_start_q <= at_origin && active;
      end
      // A set event wins over a simultaneous clear.
      if (underflow_set) begin
        underflow_q <= 1'b1;
      end else if (io_err_clr) begin
        underflow_q <= 1'b0;
      end
      if (sync_err_set) begin
        sync_err_q <= 1'b1;
      end else if (io_err_clr) begin
        sync_err_q <= 1'b0;
      end
    end
  end

  assign io_den         = den_q;
  assign io_hsync       = hsync_q;
  assign io_vsync       = vsync_q;
  assign io_data        = data_q;
  assign io_frame_start = frame_start_q;
  assign io_underflow   = underflow_q;
  assign io_sync_err    = sync_err_q;

endmodule

// File: doc/gslcd_timing_gen.md
# gslcd_timing_gen

Parametrised LCD timing generator and pixel sequencer, the next-generation core behind the GameSlab LCD wrapper. It produces DEN/HSYNC/VSYNC/DATA for a parallel RGB panel from compile-time-configurable porch, sync and active geometry, with programmable sync polarity. Pixels come either from an upstream ready/valid pixel stream (frame-buffer DMA FIFO) or from a built-in test-pattern engine. The block sits in the pixel-clock domain between the pixel FIFO read side and the panel pins.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP / H_SYNC / H_BP, 40 / 48 / 40, horizontal front porch / sync / back porch, in pixels, each ≥1
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 13 / 3 / 29, vertical porch / sync / back porch, in lines, each ≥1
- HSYNC_POL / VSYNC_POL, 0 / 0, 1 = sync active-high, 0 = active-low
- COMP_WIDTH, 8, bits per colour component; DATA_WIDTH = 3*COMP_WIDTH, packed {R,G,B}
- CNT_WIDTH, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- io_pclk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- io_enable  in  1  run timing; low holds the block idle
- io_mode  in  2  0 stream, 1 solid, 2 colour bars, 3 gradient
- io_color  in  DATA_WIDTH  solid-fill colour (mode 1)
- io_pixel_valid  in  1  upstream pixel valid
- io_pixel_data  in  DATA_WIDTH  upstream pixel
- io_pixel_sof  in  1  marks first pixel of a frame
- io_pixel_ready  out  1  pixel consumed this cycle when valid
- io_den / io_hsync / io_vsync  out  1  panel controls
- io_data  out  DATA_WIDTH  panel pixel
- io_frame_start  out  1  one-cycle pulse with first active pixel
- io_underflow  out  1  sticky: active pixel needed, none valid
- io_sync_err  out  1  sticky: frame-start pixel lacked sof
- io_err_clr  in  1  clears both sticky flags

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1 then wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- Per-line region order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical is identical in lines; vsync changes only when h_cnt = 0.
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- io_enable low: counters forced to (0,0) next cycle; den 0, syncs inactive level, data 0, ready 0. Counting begins at (0,0) on the first enabled cycle. Deassert mid-frame aborts the frame immediately.
- Mode is latched into mode_q only when enabled and (h_cnt,v_cnt) = (0,0); mid-frame io_mode changes take effect next frame. io_color is used live.
- Stream mode: io_pixel_ready = io_enable && mode_q==0 && active (combinational from registered state, independent of valid). Ready&&valid → pixel output. Ready&&!valid → output 0, set io_underflow, counters keep running (no stall).
- At (0,0) with ready&&valid&&!sof → set io_sync_err; pixel still consumed and shown. sof elsewhere is ignored.
- Solid: io_color. Bars: 8 bars of width H_ACTIVE/8 (last bar absorbs remainder), order white, yellow, cyan, green, magenta, red, blue, black (components all-ones/zero). Bar index via counter reset at h_cnt=0, no divider. Gradient: R = h_cnt[COMP_WIDTH-1:0], G = v_cnt[COMP_WIDTH-1:0], B = (h_cnt+v_cnt) mod 2^COMP_WIDTH.
- io_err_clr clears flags; a set event in the same cycle wins.

## Timing
- Reset: h_cnt=v_cnt=0, mode_q=0, io_den=0, io_hsync=!HSYNC_POL, io_vsync=!VSYNC_POL, io_data=0, io_frame_start=0, io_underflow=0, io_sync_err=0; io_pixel_ready=0 during and after reset until enabled.
- Outputs registered, 1-cycle latency from counter state; den, syncs, data and frame_start mutually aligned.
- io_frame_start asserts on the same cycle io_den first rises in a frame.
- Frame period exactly H_TOTAL*V_TOTAL cycles; hsync width H_SYNC cycles; vsync width V_SYNC*H_TOTAL cycles.
- Reset mid-frame overrides enable and all state on the next edge.

## Test plan
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), COMP_WIDTH 8, polarities 0.
- Enable, mode 1, io_color 0x123456 → den high 8 cycles per line for 4 lines, data 0x123456; hsync low 2 cycles starting 10 cycles after den rise; frame_start every 98 cycles.
- Mode 0, valid always, data = incrementing count from 0 with sof on first → 32 pixels per frame appear in order 0..31, one-cycle after ready; flags stay 0.
- Mode 0, valid dropped for pixel 5 → io_data 0 at that slot, io_underflow=1 until io_err_clr; later pixels not shifted.
- Mode 0, first pixel with sof=0 → io_sync_err=1; pulse io_err_clr with a concurrent set → flag remains 1.
- Mode 2 → line reads FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; change io_mode to 3 mid-frame → pattern switches only at next frame_start; gradient pixel (3,2) = 0x030205.
- Drop io_enable mid-line, then reset mid-frame → outputs idle next cycle (den 0, hsync/vsync 1, data 0); restart yields frame_start exactly at first enabled cycle+1.
